conv_window_sequencer: RTL and testbench
========================================

// Module: conv_window_sequencer
// PURPOSE
//  Sequences one full 2-D convolution pass: walks every valid output pixel and every kernel tap.
//  Issues image/kernel read addresses each cycle and drives MAC clear/accumulate strobes.
//  Issues filtered-image write strobes.
//  Sits between the image/kernel ROMs (1-cycle read latency) and the MAC + filtered-image RAM.
//  Started by a one-cycle start pulse; reports busy/done.
// PARAMETERS
//  IMG_SIZE  10  square input image side, pixels (row-major, addr = row*IMG_SIZE+col)
//  KER_SIZE  3   square kernel side; kernel addr = kr*KER_SIZE+kc
//  ADDR_W    16  width of all address outputs
//  derived: OUT_SIZE = IMG_SIZE-KER_SIZE+1 (8); TAPS = KER_SIZE*KER_SIZE (9)
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous reset, active-low
//  start       in   1       begin pass; sampled only in IDLE
//  hold        in   1       freeze: all state, counters and pipeline regs keep value; strobes forced 0
//  busy        out  1       pass in progress
//  done        out  1       one-cycle pulse, pass complete
//  rd_en       out  1       image/kernel read strobe
//  imAddr      out  ADDR_W  image read address
//  kAddr       out  ADDR_W  kernel read address
//  mac_clr     out  1       MAC: load product (first tap of a pixel), discard old sum
//  mac_en      out  1       MAC: accumulate product (every tap, incl. first)
//  wr_en       out  1       write MAC result to filtered image
//  filtimAddr  out  ADDR_W  filtered-image write address = orow*OUT_SIZE+ocol
// BEHAVIOUR
//  Reset (rst=0, any time, incl. mid-pass): state=IDLE, all counters 0, every output 0.
//  No partial-pass resume after reset.
//  FSM: IDLE -> RUN (start=1) -> DRAIN (last tap issued) -> DONE (2 drain cycles) -> IDLE.
//  IDLE: outputs 0; start=1 at edge E0 -> RUN; first address valid in cycle after E0.
//  RUN: every non-hold cycle rd_en=1 and one tap is issued:
//    imAddr=(orow+kr)*IMG_SIZE+(ocol+kc), kAddr=kr*KER_SIZE+kc.
//  Counter order, innermost first: kc, kr, ocol, orow.
//    Each counter wraps to 0 at its limit (KER_SIZE-1 or OUT_SIZE-1) and carries to the next.
//  Last tap is orow=ocol=OUT_SIZE-1, kr=kc=KER_SIZE-1; next state is DRAIN.
//  Strobe pipeline (matches 1-cycle ROM latency):
//    mac_en = rd_en delayed 1 cycle.
//    mac_clr = (kr==0 && kc==0 issued) delayed 1 cycle.
//    wr_en = (kr==kc==KER_SIZE-1 issued) delayed 2 cycles.
//    filtimAddr = pixel index delayed 2 cycles, held stable with wr_en.
//  DRAIN: rd_en=0; pipeline empties (2 cycles); last wr_en falls in DRAIN.
//  DONE: done=1 for exactly one cycle, then IDLE.
//  busy=1 in RUN, DRAIN and DONE; 0 in IDLE.
//  Latency, no hold: TAPS*OUT_SIZE^2 = 576 issue cycles (cycles 1..576).
//    Last wr_en in cycle 578; done in cycle 579; busy falls in cycle 580.
//  hold=1: counters, FSM and delay regs do not advance.
//    rd_en/mac_en/mac_clr/wr_en/done read 0 while held.
//    Addresses keep their values. Sequence resumes unchanged when hold drops.
//  start while busy: ignored. start and hold together in IDLE: start wins, but no issue until hold=0.
//  Arithmetic: counters clog2-sized; address products computed at ADDR_W, unsigned, no wrap.
//    Parameters must satisfy IMG_SIZE^2 < 2^ADDR_W.
// STRUCTURE
//  Shared package conv_pkg: FSM state encoding (IDLE/RUN/DRAIN/DONE).
//    Also holds the IMG_SIZE/KER_SIZE defaults and derived OUT_SIZE/TAPS.
//  One sub-module: conv_strobe_pipe, a 2-stage delay line for mac_en/mac_clr/wr_en/filtimAddr
//    with hold-enable and async clear.
//  Counters and FSM live in the top.
// TESTING
//  1 Reset then start pulse -> cycle1: imAddr=0, kAddr=0. Cycle 3: imAddr=2.
//    Cycle 4: imAddr=10, kAddr=3. Cycle 9: imAddr=22, kAddr=8.
//  2 Full pass -> exactly 64 wr_en; filtimAddr 0..63 ascending; first wr_en cycle 11.
//    mac_clr in cycles 2,11,20,...; done once, cycle 579.
//  3 Pixel (orow=7,ocol=7) -> imAddr sequence 77,78,79,87,88,89,97,98,99; wr_en with filtimAddr=63.
//  4 hold=1 for 5 cycles at cycle 100 -> strobes 0 during hold.
//    Address trace identical after shift by 5; done at cycle 584.
//  5 start re-pulsed at cycle 200 -> no effect. Start in IDLE after done -> new pass from imAddr=0.
//  6 rst low at cycle 300 (async, mid-cycle) -> all outputs 0 immediately.
//    After release + start, pass restarts at imAddr=0, kAddr=0.

Source files
------------

// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM encoding and default geometry for the convolution sequencer
//   IDLE/RUN/DRAIN/DONE pass states; default image/kernel sides and derived output side and tap count
package conv_pkg;
    localparam int IMG_SIZE_DEF = 10;
    localparam int KER_SIZE_DEF = 3;
    localparam int OUT_SIZE_DEF = IMG_SIZE_DEF - KER_SIZE_DEF + 1;
    localparam int TAPS_DEF     = KER_SIZE_DEF * KER_SIZE_DEF;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
endpackage

// File: rtl/conv_strobe_pipe.sv
// conv_strobe_pipe: 2-stage delay line aligning MAC/write strobes with 1-cycle ROM latency
//   in : clk, rst (async, active-low), hold (freeze + gate strobes), en_in/clr_in/wr_in, pix_in
//   out: mac_en, mac_clr (1-cycle delay), wr_en, filtimAddr (2-cycle delay)
module conv_strobe_pipe #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hold,
    input  logic              en_in,
    input  logic              clr_in,
    input  logic              wr_in,
    input  logic [ADDR_W-1:0] pix_in,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] filtimAddr
);
    logic              en1, clr1, wr1, wr2;
    logic [ADDR_W-1:0] pix1, pix2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            en1  <= 1'b0;
            clr1 <= 1'b0;
            wr1  <= 1'b0;
            wr2  <= 1'b0;
            pix1 <= '0;
            pix2 <= '0;
        end else if (!hold) begin
            en1  <= en_in;
            clr1 <= clr_in;
            wr1  <= wr_in;
            wr2  <= wr1;
            pix1 <= pix_in;
            pix2 <= pix1;
        end
    end
    // strobes read 0 while frozen so a held cycle never double-counts
    assign mac_en     = en1 & ~hold;
    assign mac_clr    = clr1 & ~hold;
    assign wr_en      = wr2 & ~hold;
    assign filtimAddr = pix2;
endmodule

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks every output pixel and kernel tap of one 2-D convolution pass
//   in : clk, rst (async, active-low), start (pulse, IDLE only), hold (freeze)
//   out: busy, done, rd_en, imAddr, kAddr (tap issue), mac_clr, mac_en, wr_en, filtimAddr
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int IMG_SIZE = IMG_SIZE_DEF,
    parameter int KER_SIZE = KER_SIZE_DEF,
    parameter int ADDR_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] imAddr,
    output logic [ADDR_W-1:0] kAddr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] filtimAddr
);
    localparam int OUT_SIZE = IMG_SIZE - KER_SIZE + 1;
    localparam int KW = KER_SIZE > 1 ? $clog2(KER_SIZE) : 1;
    localparam int OW = OUT_SIZE > 1 ? $clog2(OUT_SIZE) : 1;
    state_t            state, state_nx;
    logic [KW-1:0]     kc, kr;
    logic [OW-1:0]     ocol, orow;
    logic              kc_last, kr_last, ocol_last, orow_last, tap_last;
    logic [ADDR_W-1:0] pix;
    assign kc_last   = kc == KW'(KER_SIZE - 1);
    assign kr_last   = kr == KW'(KER_SIZE - 1);
    assign ocol_last = ocol == OW'(OUT_SIZE - 1);
    assign orow_last = orow == OW'(OUT_SIZE - 1);
    assign tap_last  = kc_last && kr_last && ocol_last && orow_last;
    assign rd_en     = state == RUN && !hold;
    assign busy      = state != IDLE;
    assign done      = state == DONE && !hold;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end
    // start in IDLE is taken even under hold; the first tap then waits for hold to drop
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = rd_en && tap_last ? DRAIN : RUN;
            DRAIN:   state_nx = wr_en ? DONE : DRAIN;
            DONE:    state_nx = hold ? DONE : IDLE;
            default: state_nx = IDLE;
        endcase
    end
    // counters wrap to 0 after the last tap, so IDLE/DRAIN addresses read 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kc   <= '0;
            kr   <= '0;
            ocol <= '0;
            orow <= '0;
        end else if (rd_en) begin
            kc   <= kc_last ? '0 : kc + 1'b1;
            kr   <= kc_last ? (kr_last ? '0 : kr + 1'b1) : kr;
            ocol <= kc_last && kr_last ? (ocol_last ? '0 : ocol + 1'b1) : ocol;
            orow <= kc_last && kr_last && ocol_last ? (orow_last ? '0 : orow + 1'b1) : orow;
        end
    end
    assign imAddr = (ADDR_W'(orow) + ADDR_W'(kr)) * ADDR_W'(IMG_SIZE) + ADDR_W'(ocol) + ADDR_W'(kc);
    assign kAddr  = ADDR_W'(kr) * ADDR_W'(KER_SIZE) + ADDR_W'(kc);
    assign pix    = ADDR_W'(orow) * ADDR_W'(OUT_SIZE) + ADDR_W'(ocol);
    conv_strobe_pipe #(.ADDR_W(ADDR_W)) u_pipe (
        .clk        (clk),
        .rst        (rst),
        .hold       (hold),
        .en_in      (rd_en),
        .clr_in     (rd_en && kc == '0 && kr == '0),
        .wr_in      (rd_en && kc_last && kr_last),
        .pix_in     (pix),
        .mac_en     (mac_en),
        .mac_clr    (mac_clr),
        .wr_en      (wr_en),
        .filtimAddr (filtimAddr)
    );
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb_conv_window_sequencer: random-hold passes checked against a per-step arithmetic model of one pass
module tb_conv_window_sequencer;
    localparam int IMG = 10, KER = 3, OUT = IMG - KER + 1, TAPS = KER * KER, NIS = TAPS * OUT * OUT;
    typedef struct {
        logic busy, done, rd, men, mclr, wr;
        int   im, k, fa;
    } exp_t;
    logic        clk = 0, rst = 0, start = 0, hold = 0;
    logic        busy, done, rd_en, mac_clr, mac_en, wr_en;
    logic [15:0] imAddr, kAddr, filtimAddr;
    int total = 0, bad = 0;
    int p = 0, cnum = 0, wr_cnt = 0, done_cnt = 0, done_at = -1;
    logic was_held = 0;
    logic [15:0] last_im = 0, last_k = 0;
    conv_window_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .busy(busy), .done(done),
        .rd_en(rd_en), .imAddr(imAddr), .kAddr(kAddr), .mac_clr(mac_clr), .mac_en(mac_en),
        .wr_en(wr_en), .filtimAddr(filtimAddr)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s (cycle %0d): got %0d want %0d", tag, cnum, obs, expv);
        end
    endtask
    // expected outputs at pass step p (1 = first issue cycle, 0 = idle), no hold
    function automatic exp_t model(input int s);
        exp_t e;
        int   i, t, px;
        e = '{default: 0};
        e.busy = s >= 1 && s <= NIS + 3;
        e.done = s == NIS + 3;
        if (s >= 1 && s <= NIS) begin
            i = s - 1;
            t = i % TAPS;
            px = i / TAPS;
            e.rd = 1;
            e.im = (px / OUT + t / KER) * IMG + px % OUT + t % KER;
            e.k = t;
        end
        if (s >= 2 && s <= NIS + 1) begin
            e.men = 1;
            e.mclr = (s - 2) % TAPS == 0;
        end
        if (s >= 3 && s <= NIS + 2 && (s - 3) % TAPS == TAPS - 1) begin
            e.wr = 1;
            e.fa = (s - 3) / TAPS;
        end
        return e;
    endfunction
    task automatic step(input logic hv, input logic st);
        exp_t e;
        hold = hv;
        start = st;
        cnum = (p == 0 && st) ? 0 : cnum + 1;
        @(negedge clk);
        e = model(p);
        chk("busy", busy, e.busy);
        if (hv) begin
            chk("held_rd_en", rd_en, 0);
            chk("held_mac_en", mac_en, 0);
            chk("held_mac_clr", mac_clr, 0);
            chk("held_wr_en", wr_en, 0);
            chk("held_done", done, 0);
            if (was_held) begin
                chk("held_imAddr", imAddr, last_im);
                chk("held_kAddr", kAddr, last_k);
            end
        end else begin
            chk("rd_en", rd_en, e.rd);
            chk("mac_en", mac_en, e.men);
            chk("mac_clr", mac_clr, e.mclr);
            chk("wr_en", wr_en, e.wr);
            chk("done", done, e.done);
            if (e.rd || p == 0) begin
                chk("imAddr", imAddr, e.im);
                chk("kAddr", kAddr, e.k);
            end
            if (e.wr || p == 0) chk("filtimAddr", filtimAddr, e.fa);
        end
        if (wr_en) wr_cnt++;
        if (done) begin
            done_cnt++;
            done_at = cnum;
        end
        was_held = hv;
        last_im = imAddr;
        last_k = kAddr;
        if (p == 0 ? st : !hv) p++;
        if (p > NIS + 3) p = 0;
        @(posedge clk);
        #1;
    endtask
    initial begin
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_imAddr", imAddr, 0);
        chk("rst_wr_en", wr_en, 0);
        @(posedge clk);
        #1;
        rst = 1;
        step(0, 0);
        // pass 1: no hold
        wr_cnt = 0; done_cnt = 0; done_at = -1;
        step(0, 1);
        for (int c = 1; c <= 585; c++) step(0, 0);
        chk("p1_wr_count", wr_cnt, 64);
        chk("p1_done_count", done_cnt, 1);
        chk("p1_done_cycle", done_at, 579);
        // pass 2: hold at cycles 100..104, start re-pulsed at 200
        wr_cnt = 0; done_cnt = 0; done_at = -1;
        step(0, 1);
        for (int c = 1; c <= 590; c++) step(c >= 100 && c <= 104, c == 200);
        chk("p2_wr_count", wr_cnt, 64);
        chk("p2_done_count", done_cnt, 1);
        chk("p2_done_cycle", done_at, 584);
        // pass 3: start together with hold, then random hold and stray starts
        wr_cnt = 0; done_cnt = 0;
        step(1, 1);
        for (int n = 0; n < 4000 && p != 0; n++)
            step($urandom_range(0, 3) == 0, $urandom_range(0, 20) == 0);
        step(0, 0);
        chk("p3_idle_busy", busy, 0);
        chk("p3_wr_count", wr_cnt, 64);
        chk("p3_done_count", done_cnt, 1);
        // pass 4: asynchronous reset mid-pass, then restart
        step(0, 1);
        for (int c = 1; c < 300; c++) step($urandom_range(0, 5) == 0, 0);
        #2;
        rst = 0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_rd_en", rd_en, 0);
        chk("arst_imAddr", imAddr, 0);
        chk("arst_kAddr", kAddr, 0);
        chk("arst_mac_en", mac_en, 0);
        chk("arst_mac_clr", mac_clr, 0);
        chk("arst_wr_en", wr_en, 0);
        chk("arst_filtimAddr", filtimAddr, 0);
        chk("arst_done", done, 0);
        @(posedge clk);
        #1;
        rst = 1;
        hold = 0;
        p = 0;
        was_held = 0;
        step(0, 0);
        step(0, 1);
        for (int c = 1; c <= 30; c++) step(0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
